// File: rtl/subband_pkg.sv
// Shared types for the subband decimator: sample width, decimated pair payload
// and serialiser state encoding.
package subband_pkg;

  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] y1;
    logic signed [DATA_W-1:0] y2;
  } pair_t;

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } ser_state_t;

endpackage

// File: rtl/subband_pair_fifo.sv
// First-word fall-through FIFO of decimated pairs; dout, full and empty are
// registered. A push into a full FIFO is accepted when a pop happens in the same cycle.
module subband_pair_fifo
  import subband_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  pair_t din,
  output pair_t dout,
  output logic  full,
  output logic  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  pair_t                 mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_nxt;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  push_ok;
  logic                  pop_ok;
  pair_t                 head_nxt;

  // Next head: the incoming pair if nothing older survives this cycle, else memory.
  always_comb begin
    push_ok   = push && (!full || pop);
    pop_ok    = pop && !empty;
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
    rd_nxt    = rd_ptr + DEPTH_LOG2'(pop_ok);
    head_nxt  = (count == CW'(pop_ok)) ? din : mem[rd_nxt];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      dout   <= '0;
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_nxt;
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      empty  <= (count_nxt == '0);
      full   <= (count_nxt == CW'(DEPTH));
      if (count_nxt != '0) dout <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/subband_decimator.sv
// Decimates both subband channels by 2^DECIM_LOG2, buffers pairs and serialises
// them ch1 then ch2. Define DECIM_AVG_EN for averaging, else plain downsampling.
module subband_decimator
  import subband_pkg::*;
#(
  parameter int unsigned DECIM_LOG2      = 1,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x_in1,
  input  logic signed [DATA_W-1:0] x_in2,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned D  = 1 << DECIM_LOG2;
  localparam int unsigned PW = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;

  logic [PW-1:0] phase;
  logic          first_ph;
  logic          last_ph;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  pair_t         new_pair;
  pair_t         head;
  ser_state_t    state;

  assign first_ph = (phase == '0);
  assign last_ph  = (phase == PW'(D - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        phase <= '0;
    else if (in_valid) phase <= last_ph ? '0 : phase + PW'(1);
  end

`ifdef DECIM_AVG_EN
  localparam int unsigned ACC_W = DATA_W + DECIM_LOG2;

  logic signed [ACC_W-1:0] acc1, acc2, base1, base2, sum1, sum2;

  // Phase 0 restarts the group, so its sum is just the sample itself.
  always_comb begin
    base1 = acc1;
    base2 = acc2;
    if (first_ph) begin
      base1 = '0;
      base2 = '0;
    end
    sum1        = base1 + ACC_W'(x_in1);
    sum2        = base2 + ACC_W'(x_in2);
    new_pair.y1 = DATA_W'(sum1 >>> DECIM_LOG2);
    new_pair.y2 = DATA_W'(sum2 >>> DECIM_LOG2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc1 <= '0;
      acc2 <= '0;
    end else if (in_valid) begin
      acc1 <= sum1;
      acc2 <= sum2;
    end
  end
`else
  logic signed [DATA_W-1:0] samp1, samp2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp1 <= '0;
      samp2 <= '0;
    end else if (in_valid && first_ph) begin
      samp1 <= x_in1;
      samp2 <= x_in2;
    end
  end

  always_comb begin
    new_pair.y1 = first_ph ? x_in1 : samp1;
    new_pair.y2 = first_ph ? x_in2 : samp2;
  end
`endif

  assign push      = in_valid && last_ph;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready && (state == CH2);

  subband_pair_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (new_pair),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // A pair is only lost when the FIFO is full and no pop frees a slot this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          overflow <= 1'b0;
    else if (push && fifo_full && !pop)  overflow <= 1'b1;
    else if (ovf_clr)                    overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       state <= CH1;
    else if (out_valid && out_ready)  state <= (state == CH1) ? CH2 : CH1;
  end

  assign out_ch   = (state == CH2);
  assign out_data = (state == CH2) ? head.y2 : head.y1;

endmodule

// File: tb/tb_subband_decimator.sv
// Randomized bench for subband_decimator (DECIM_LOG2=1, 4-pair FIFO) against a
// group/queue reference model; honours DECIM_AVG_EN like the design.
module tb_subband_decimator;

  localparam int DL    = 1;
  localparam int FDL   = 2;
  localparam int D     = 1 << DL;
  localparam int DEPTH = 1 << FDL;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] x_in1 = '0;
  logic signed [15:0] x_in2 = '0;
  logic signed [15:0] out_data;
  logic               out_ch;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               overflow;
  logic               ovf_clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: samples of the current group, FIFO of pairs, word position in pair.
  int m_q1[$];
  int m_q2[$];
  int m_n, m_s1, m_s2, m_f1, m_f2;
  bit m_half, m_ovf;

  subband_decimator #(.DECIM_LOG2(DL), .FIFO_DEPTH_LOG2(FDL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in1(x_in1), .x_in2(x_in2),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int floor_div(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  function automatic int reduce(input int sum, input int first);
`ifdef DECIM_AVG_EN
    return floor_div(sum, D);
`else
    return first;
`endif
  endfunction

  function automatic logic signed [15:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 16'sh7FFF;
      1:       return 16'sh8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic model_clear();
    m_q1.delete();
    m_q2.delete();
    m_n = 0; m_s1 = 0; m_s2 = 0; m_f1 = 0; m_f2 = 0;
    m_half = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Called at a negedge: check outputs, drive one cycle of inputs, advance model, wait.
  task automatic step(input bit iv, input logic signed [15:0] a, input logic signed [15:0] b,
                      input bit rdy, input bit clr);
    bit hs, pop, push_req;
    int y1, y2;
    check("valid", out_valid, 16'(m_q1.size() != 0));
    if (m_q1.size() != 0) begin
      check("data", out_data, 16'(m_half ? m_q2[0] : m_q1[0]));
      check("ch", out_ch, 16'(m_half));
    end
    check("ovf", overflow, 16'(m_ovf));
    in_valid = iv; x_in1 = a; x_in2 = b; out_ready = rdy; ovf_clr = clr;
    hs = (m_q1.size() != 0) && rdy;
    pop = hs && m_half;
    push_req = 1'b0;
    if (iv) begin
      if (m_n == 0) begin
        m_s1 = int'(a); m_s2 = int'(b); m_f1 = int'(a); m_f2 = int'(b);
      end else begin
        m_s1 += int'(a); m_s2 += int'(b);
      end
      m_n++;
      if (m_n == D) begin
        y1 = reduce(m_s1, m_f1);
        y2 = reduce(m_s2, m_f2);
        m_n = 0;
        push_req = 1'b1;
      end
    end
    if (push_req && m_q1.size() == DEPTH && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (pop) begin
      void'(m_q1.pop_front());
      void'(m_q2.pop_front());
    end
    if (push_req && (m_q1.size() < DEPTH)) begin
      m_q1.push_back(y1);
      m_q2.push_back(y2);
    end
    if (hs) m_half = !m_half;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks outputs clear without a clock.
  task automatic do_reset();
    #2 reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    check("rst_valid", out_valid, 16'd0);
    check("rst_data", out_data, 16'd0);
    check("rst_ch", out_ch, 16'd0);
    check("rst_ovf", overflow, 16'd0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int y1e, y2e, thr;
    logic signed [15:0] a, b;
    model_clear();
    @(negedge clk);
    do_reset();

`ifdef DECIM_AVG_EN
    y1e = 150; y2e = -4;
`else
    y1e = 100; y2e = -3;
`endif
    step(1'b1, 16'sd100, -16'sd3, 1'b1, 1'b0);
    step(1'b1, 16'sd200, -16'sd4, 1'b1, 1'b0);
    check("tp_y1_valid", out_valid, 16'd1);
    check("tp_y1", out_data, 16'(y1e));
    check("tp_y1_ch", out_ch, 16'd0);
    step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
    check("tp_y2", out_data, 16'(y2e));
    check("tp_y2_ch", out_ch, 16'd1);
    step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
    check("tp_pair_done", out_valid, 16'd0);

    // Backpressure: five groups, four fit, the fifth is dropped.
    for (int i = 0; i < 10; i++) step(1'b1, rnd_val(), rnd_val(), 1'b0, 1'b0);
    check("tp_ovf_set", overflow, 16'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
    check("tp_drained", out_valid, 16'd0);
    check("tp_ovf_sticky", overflow, 16'd1);
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1);
    check("tp_ovf_clr", overflow, 16'd0);

    // Full FIFO with CH2 pop and push on the same edge.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, rnd_val(), rnd_val(), 1'b1, 1'b0);
    step(1'b1, rnd_val(), rnd_val(), 1'b1, 1'b0);
    check("tp_full_pp_ovf", overflow, 16'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
    check("tp_full_pp_drained", out_valid, 16'd0);

    // Reset mid-group and mid-pair, then a clean post-reset pair.
    for (int i = 0; i < 2; i++) step(1'b1, rnd_val(), rnd_val(), 1'b0, 1'b0);
    step(1'b1, rnd_val(), rnd_val(), 1'b1, 1'b0);
    check("tp_mid_pair_ch", out_ch, 16'd1);
    do_reset();
    a = rnd_val(); b = rnd_val();
    step(1'b1, a, b, 1'b1, 1'b0);
    step(1'b1, a, b, 1'b1, 1'b0);
    check("tp_post_rst_valid", out_valid, 16'd1);
    check("tp_post_rst_y1", out_data, a);
    for (int i = 0; i < 3; i++) step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);

    // Random traffic at several consumer duty cycles, with input gaps.
    for (int blk = 0; blk < 4; blk++) begin
      thr = (blk == 0) ? 25 : (blk == 1) ? 50 : (blk == 2) ? 90 : 100;
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 3) != 0, rnd_val(), rnd_val(),
             $urandom_range(1, 100) <= thr, $urandom_range(0, 49) == 0);
      if (blk == 1) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/subband_decimator.md
# subband_decimator

Downstream stage of the two-channel lattice filter bank. Takes the two 16-bit subband outputs each sample and decimates both channels by 2^DECIM_LOG2. It buffers the decimated pairs in a small FIFO and serialises them onto one valid/ready output stream, channel 1 first, then channel 2. It lets the filter bank run at full rate while a slower consumer such as a packetiser or DMA drains subband data with backpressure.

## Interface
- DECIM_LOG2, 1: decimation factor D = 2^DECIM_LOG2; legal range 0..4 (0 = no decimation).
- FIFO_DEPTH_LOG2, 2: FIFO holds 2^FIFO_DEPTH_LOG2 decimated pairs.
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted (0) clears all state immediately.
- in_valid  input  1  x_in1/x_in2 carry a new sample pair this cycle. Tie high when fed directly by the filter bank.
- x_in1  input  16  channel-1 subband sample, signed two's complement.
- x_in2  input  16  channel-2 subband sample, signed two's complement.
- out_data  output  16  serialised decimated sample, signed.
- out_ch  output  1  0 = out_data is channel 1, 1 = channel 2.
- out_valid  output  1  out_data/out_ch valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- overflow  output  1  sticky: a decimated pair was dropped because the FIFO was full.
- ovf_clr  input  1  synchronous clear of overflow.

## Operation
- Phase counter, DECIM_LOG2 bits:
  - Increments on each in_valid and wraps at D-1→0.
  - Ignores cycles with in_valid=0.
  - With DECIM_LOG2=0 every accepted pair is a decimated pair.
- The accepted sample at phase D-1 completes a group and produces one decimated pair (y1, y2).
- Arithmetic with averaging (see Configuration):
  - Per-channel signed accumulator, 16+DECIM_LOG2 bits, loaded with the sample at phase 0 and added to at the later phases.
  - Result = accumulator >>> DECIM_LOG2 (arithmetic shift, truncation toward −∞, no rounding). The result always fits in 16 bits, so no saturation is needed.
- Push to the FIFO on the edge that accepts the phase D-1 sample.
  - Push succeeds if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the new pair is dropped, FIFO contents are unchanged, and overflow is set.
- Overflow flag:
  - Set has priority over ovf_clr in the same cycle.
  - Remains set until ovf_clr or reset.
- Serialiser FSM, states CH1 and CH2, on the FIFO head (first-word fall-through):
  - out_valid = FIFO not empty.
  - CH1: out_data = head.y1, out_ch = 0. On handshake go to CH2.
  - CH2: out_data = head.y2, out_ch = 1. On handshake pop the head and go to CH1.
  - out_data/out_ch are stable while out_valid && !out_ready.
- Reset values:
  - out_data = 0, out_ch = 0, out_valid = 0, overflow = 0.
  - Phase counter = 0, accumulators = 0, FSM = CH1, FIFO empty.
  - Reset mid-group discards the partial group. Reset mid-pair discards the unsent channel-2 word.

## Timing
- Latency from the edge accepting the phase D-1 sample to out_valid=1 (empty FIFO) is 0 extra edges: out_valid is high in the following cycle.
- A pair occupies 2 output handshakes. Sustained throughput without loss requires a mean out_ready duty of ≥ 2/D.
- With full FIFO, a CH2 handshake, and a push in the same cycle, both occur: count stays at full and no overflow is flagged.
- in_valid gaps stretch the group with no effect on the result.

## Configuration
- DECIM_AVG_EN defined: integrate-and-dump averaging as above.
- DECIM_AVG_EN undefined: plain downsampling.
  - The decimated pair is the sample accepted at phase 0; later phases are discarded.
  - No accumulators are built; push timing is unchanged (phase D-1).

## Structure
- Package subband_pkg holds:
  - DATA_W = 16.
  - Packed struct pair_t {y1, y2}.
  - Enum ser_state_t {CH1, CH2}.
- Sub-module subband_pair_fifo:
  - Synchronous FIFO of pair_t with first-word fall-through.
  - Ports: push, pop, din, dout, full, empty.
  - Simultaneous push/pop is legal when full.
- Top level contains the phase counter, accumulators, overflow logic and serialiser FSM.

## Test plan
- Averaging, DECIM_AVG_EN on, DECIM_LOG2=1, out_ready=1:
  - Stimulus: x_in1 = 100, 200 and x_in2 = −3, −4.
  - Response: output 150 (ch 0) then −4 (ch 1).
  - The same run with the macro off outputs 100 then −3.
- in_valid gaps, DECIM_LOG2=2, in_valid toggling 1,0,1,0…:
  - Stimulus: x_in1 = 4, 8, 12, 16.
  - Response: exactly one pair with y1 = 10, emitted one cycle after the 4th accepted sample.
- Backpressure/overflow, FIFO_DEPTH_LOG2=2, DECIM_LOG2=1, out_ready=0:
  - Stimulus: 10 input pairs.
  - Response: 4 pairs stored and overflow=1 after the 10th sample.
  - Then out_ready=1 drains exactly 8 words, in order and matching the first 4 pairs.
  - ovf_clr then clears overflow.
- Full push+pop:
  - Stimulus: FIFO full, FSM in CH2, out_ready=1 in the cycle a new pair completes.
  - Response: pop and push both occur and overflow stays 0.
- Async reset:
  - Stimulus: reset low asserted mid-group and between CH1 and CH2 handshakes.
  - Response: outputs go to 0 immediately without a clock edge.
  - After release, the first output pair uses only post-reset samples.
- DECIM_LOG2=0:
  - Stimulus: continuous in_valid with out_ready=1.
  - Response: FIFO fills and overflow sets.
  - With out_ready held 1, the output sequence is x1[0], x2[0], x1[1], x2[1]… until overflow drops pairs.
